// File: rtl/halt_bcast_r.sv
// Pipelined halt broadcast: registered fan-out tree to WIDTH lanes, registered AND/OR
// ack-collection trees, and a req/ack handshake FSM with timeout.
module halt_bcast_r #(
    parameter int WIDTH       = 8,
    parameter int FANOUT      = 6,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt_req,
    output logic             halt_ack,
    output logic             halt_timeout,
    output logic             busy,
    output logic [WIDTH-1:0] lane_halt,
    input  logic [WIDTH-1:0] lane_ack
);

    function automatic int calc_levels(int w, int f);
        int n = 1;
        int p = f;
        while (p < w) begin
            p = p * f;
            n++;
        end
        return n;
    endfunction

    function automatic int ipow(int b, int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic int cdiv(int a, int b);
        return (a + b - 1) / b;
    endfunction

    localparam int L    = calc_levels(WIDTH, FANOUT);
    localparam int CMAX = (L > ACK_TIMEOUT) ? L : ACK_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] L_LAST  = CW'(L - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE, S_WAIT_ACK, S_HELD, S_RELEASE, S_WAIT_CLR
    } state_t;

    state_t          state_q, state_d;
    logic            src_q, src_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            halt_ack_q, halt_ack_d;
    logic            timeout_q, timeout_d;
    logic            busy_q, busy_d;
    logic            ack_all, ack_any;

    // Fan-out tree: level k holds ceil(WIDTH/FANOUT^(L-k)) copies; node j feeds from j/FANOUT.
    for (genvar k = 1; k <= L; k++) begin : g_fo
        localparam int N = cdiv(WIDTH, ipow(FANOUT, L - k));
        logic [N-1:0] q;
        logic [N-1:0] d;
        for (genvar j = 0; j < N; j++) begin : g_n
            if (k == 1) begin : g_root
                assign d[j] = src_q;
            end else begin : g_int
                assign d[j] = g_fo[k-1].q[j/FANOUT];
            end
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q <= '0;
            else        q <= d;
        end
    end

    // Ack trees: level k reduces groups of up to FANOUT nodes from level k-1 (level 0 = lane_ack).
    for (genvar k = 1; k <= L; k++) begin : g_ak
        localparam int M  = cdiv(WIDTH, ipow(FANOUT, k));
        localparam int MP = cdiv(WIDTH, ipow(FANOUT, k - 1));
        logic [M-1:0] and_q, or_q;
        logic [M-1:0] and_d, or_d;
        for (genvar j = 0; j < M; j++) begin : g_n
            localparam int LO = j * FANOUT;
            localparam int HI = (((LO + FANOUT) < MP) ? (LO + FANOUT) : MP) - 1;
            if (k == 1) begin : g_leaf
                assign and_d[j] = &lane_ack[HI:LO];
                assign or_d[j]  = |lane_ack[HI:LO];
            end else begin : g_int
                assign and_d[j] = &g_ak[k-1].and_q[HI:LO];
                assign or_d[j]  = |g_ak[k-1].or_q[HI:LO];
            end
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                and_q <= '0;
                or_q  <= '0;
            end else begin
                and_q <= and_d;
                or_q  <= or_d;
            end
        end
    end

    assign ack_all = g_ak[L].and_q[0];
    assign ack_any = g_ak[L].or_q[0];

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (halt_req) begin
                    src_d     = 1'b1;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (!halt_req) begin
                    src_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (cnt_q == L_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_ACK: begin
                // An ack arriving on the timeout cycle counts as success.
                if (!halt_req) begin
                    src_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (ack_all) begin
                    state_d = S_HELD;
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_HELD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HELD: begin
                if (!halt_req) begin
                    src_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (cnt_q == L_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_CLR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_CLR: begin
                if (!ack_any) begin
                    state_d = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d     = (state_d != S_IDLE);
        halt_ack_d = (state_d == S_HELD) && ack_all;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            src_q      <= 1'b0;
            cnt_q      <= '0;
            halt_ack_q <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
            halt_ack_q <= halt_ack_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    assign lane_halt    = g_fo[L].q;
    assign halt_ack     = halt_ack_q;
    assign halt_timeout = timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_halt_bcast_r.sv
// Directed bench for halt_bcast_r: three instances (36 lanes L=2, 37 lanes L=3, 1 lane L=1)
// with a cycle-stamped expectation queue checked after each clock edge.
module tb_halt_bcast_r;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        halt_req_a, halt_ack_a, to_a, busy_a;
    logic [35:0] lane_halt_a, lane_ack_a;
    logic        halt_req_b, halt_ack_b, to_b, busy_b;
    logic [36:0] lane_halt_b, lane_ack_b;
    logic        halt_req_c, halt_ack_c, to_c, busy_c;
    logic [0:0]  lane_halt_c, lane_ack_c;

    halt_bcast_r #(.WIDTH(36), .FANOUT(6), .ACK_TIMEOUT(10)) u_a (
        .clk(clk), .rst_n(rst_n), .halt_req(halt_req_a), .halt_ack(halt_ack_a),
        .halt_timeout(to_a), .busy(busy_a), .lane_halt(lane_halt_a), .lane_ack(lane_ack_a));
    halt_bcast_r #(.WIDTH(37), .FANOUT(6), .ACK_TIMEOUT(10)) u_b (
        .clk(clk), .rst_n(rst_n), .halt_req(halt_req_b), .halt_ack(halt_ack_b),
        .halt_timeout(to_b), .busy(busy_b), .lane_halt(lane_halt_b), .lane_ack(lane_ack_b));
    halt_bcast_r #(.WIDTH(1), .FANOUT(6), .ACK_TIMEOUT(10)) u_c (
        .clk(clk), .rst_n(rst_n), .halt_req(halt_req_c), .halt_ack(halt_ack_c),
        .halt_timeout(to_c), .busy(busy_c), .lane_halt(lane_halt_c), .lane_ack(lane_ack_c));

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] val;
        string       tag;
    } exp_t;

    localparam logic [63:0] ALL36 = 64'hF_FFFF_FFFF;
    localparam logic [63:0] ALL37 = 64'h1F_FFFF_FFFF;

    exp_t sb[$];
    int   cyc;
    int   total;
    int   bad;

    function automatic logic [63:0] obs(int sig);
        case (sig)
            0:       return 64'(lane_halt_a);
            1:       return 64'(halt_ack_a);
            2:       return 64'(to_a);
            3:       return 64'(busy_a);
            4:       return 64'(lane_halt_b);
            5:       return 64'(halt_ack_b);
            6:       return 64'(busy_b);
            7:       return 64'(lane_halt_c);
            8:       return 64'(halt_ack_c);
            9:       return 64'(busy_c);
            default: return 64'hDEAD;
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] o, logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    task automatic expect_at(int dc, int sig, logic [63:0] v, string tag);
        exp_t x;
        x.cyc = cyc + dc;
        x.sig = sig;
        x.val = v;
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i].tag, obs(sb[i].sig), sb[i].val);
                sb.delete(i);
            end
        end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        halt_req_a = 1'b0; lane_ack_a = '0;
        halt_req_b = 1'b0; lane_ack_b = '0;
        halt_req_c = 1'b0; lane_ack_c = '0;
        #12;
        check("rst_lh", 64'(lane_halt_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        check("rst_ack", 64'(halt_ack_a), 64'd0);
        check("rst_to", 64'(to_a), 64'd0);

        // Request latency, ack path and release on the 36-lane instance
        halt_req_a = 1'b1;
        expect_at(1, 3, 64'd1, "t1_busy");
        expect_at(2, 0, 64'd0, "t1_lh_early");
        expect_at(3, 0, ALL36, "t1_lh");
        ticks(5);
        lane_ack_a = '1;
        expect_at(2, 1, 64'd0, "t2_ack_early");
        expect_at(3, 1, 64'd1, "t2_ack");
        ticks(15);
        check("t2_ack_hold", 64'(halt_ack_a), 64'd1);
        halt_req_a = 1'b0;
        expect_at(1, 1, 64'd0, "t2_ack_drop");
        expect_at(2, 0, ALL36, "t2_lh_hold");
        expect_at(3, 0, 64'd0, "t2_lh_rel");
        ticks(3);
        lane_ack_a = '0;
        expect_at(2, 3, 64'd1, "t2_busy_clr");
        expect_at(3, 3, 64'd0, "t2_idle");
        expect_at(3, 2, 64'd0, "t2_no_to");
        ticks(5);

        // Ack timeout with one lane stuck low; flag is sticky until the next request
        lane_ack_a = '1;
        lane_ack_a[17] = 1'b0;
        halt_req_a = 1'b1;
        expect_at(13, 2, 64'd0, "t3_to_early");
        expect_at(14, 2, 64'd1, "t3_to");
        expect_at(14, 1, 64'd0, "t3_no_ack");
        expect_at(14, 3, 64'd1, "t3_busy");
        ticks(16);
        halt_req_a = 1'b0;
        lane_ack_a = '0;
        ticks(9);
        check("t3_to_sticky", 64'(to_a), 64'd1);
        check("t3_idle", 64'(busy_a), 64'd0);

        // One-cycle request pulse aborts in DRIVE
        halt_req_a = 1'b1;
        expect_at(1, 2, 64'd0, "t4_to_clr");
        expect_at(2, 0, 64'd0, "t4_lh_pre");
        expect_at(3, 0, ALL36, "t4_lh_pulse");
        expect_at(4, 0, 64'd0, "t4_lh_drop");
        expect_at(3, 1, 64'd0, "t4_no_ack");
        expect_at(4, 3, 64'd1, "t4_busy");
        expect_at(5, 3, 64'd0, "t4_idle");
        tick();
        halt_req_a = 1'b0;
        ticks(6);

        // Ack on the timeout cycle wins, then async reset while HELD
        halt_req_a = 1'b1;
        ticks(11);
        lane_ack_a = '1;
        expect_at(3, 1, 64'd1, "t5_ack_tie");
        expect_at(3, 2, 64'd0, "t5_tie_no_to");
        ticks(5);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_lh", 64'(lane_halt_a), 64'd0);
        check("t5_rst_ack", 64'(halt_ack_a), 64'd0);
        check("t5_rst_busy", 64'(busy_a), 64'd0);
        halt_req_a = 1'b0;
        lane_ack_a = '0;
        #2 rst_n = 1'b1;
        ticks(4);
        check("t5_quiet_busy", 64'(busy_a), 64'd0);
        check("t5_quiet_lh", 64'(lane_halt_a), 64'd0);

        // Depth checks for 37 lanes (L=3) and 1 lane (L=1), acks present before DRIVE ends
        halt_req_b = 1'b1;
        lane_ack_b = '1;
        halt_req_c = 1'b1;
        lane_ack_c = '1;
        expect_at(1, 6, 64'd1, "t6_busy37");
        expect_at(3, 4, 64'd0, "t6_lh37_early");
        expect_at(4, 4, ALL37, "t6_lh37");
        expect_at(4, 5, 64'd0, "t6_ack37_early");
        expect_at(5, 5, 64'd1, "t6_ack37");
        expect_at(1, 9, 64'd1, "t6_busy1");
        expect_at(1, 7, 64'd0, "t6_lh1_early");
        expect_at(2, 7, 64'd1, "t6_lh1");
        expect_at(2, 8, 64'd0, "t6_ack1_early");
        expect_at(3, 8, 64'd1, "t6_ack1");
        ticks(6);
        halt_req_b = 1'b0;
        lane_ack_b = '0;
        halt_req_c = 1'b0;
        lane_ack_c = '0;
        ticks(12);
        check("t6_idle37", 64'(busy_b), 64'd0);
        check("t6_idle1", 64'(busy_c), 64'd0);
        check("t6_lh37_rel", 64'(lane_halt_b), 64'd0);
        check("t6_no_to", 64'({to_b, to_c}), 64'd0);

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
